// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key-schedule sequencer.
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] key_t;

   localparam int          NR_128    = 10;
   localparam logic [7:0]  RCON_INIT = 8'h01;
   localparam logic [7:0]  RCON_POLY = 8'h1b;

   // Fixed state encodings, kept stable for external tools that decode the state bits
   localparam logic [0:0]  ST_IDLE   = 1'b0;
   localparam logic [0:0]  ST_RUN    = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN
   } state_e;

   // GF(2^8) multiply-by-x; steps rcon through 01,02,04,...,80,1b,36
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ RCON_POLY) : {b[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/key_expand_ctrl_if.sv
// Handshake bundle between the key schedule and its loader/consumer.
// Optional key-store read port present when KEYEXP_STORE_EN is defined.
interface key_expand_ctrl_if #(
   parameter int RCNT_W = 4
);
   import aes_pkg::*;

   logic              start;
   key_t              key_in;
   logic              rk_valid;
   logic              rk_ready;
   key_t              rk_data;
   logic [RCNT_W-1:0] rk_idx;
   logic              busy;
   logic              done;
`ifdef KEYEXP_STORE_EN
   logic [RCNT_W-1:0] rd_idx;
   key_t              rd_data;
   logic              rd_vld;
`endif

   // Loader / round datapath side
   modport master (
`ifdef KEYEXP_STORE_EN
      output rd_idx,
      input  rd_data, rd_vld,
`endif
      output start, key_in, rk_ready,
      input  rk_valid, rk_data, rk_idx, busy, done
   );

   // Key schedule side
   modport slave (
`ifdef KEYEXP_STORE_EN
      input  rd_idx,
      output rd_data, rd_vld,
`endif
      input  start, key_in, rk_ready,
      output rk_valid, rk_data, rk_idx, busy, done
   );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, pure combinational table lookup.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   // First listed byte sits at the top index, so entry for input a lives at 255-a (= ~a)
   localparam logic [255:0][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign s_o = SBOX[~a_i];

endmodule

// File: rtl/key_expand_ctrl_subword.sv
// SubWord: four S-boxes applied bytewise, byte3..byte0.
module key_expand_ctrl_subword
   import aes_pkg::*;
(
   input  word_t word_i,
   output word_t word_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .a_i (word_i[8*gi +: 8]),
            .s_o (word_o[8*gi +: 8])
         );
      end
   endgenerate

endmodule

// File: rtl/key_expand_ctrl.sv
// Iterative AES-128 key schedule: streams rk0..rkNR over valid/ready,
// one key per accepted handshake, using a single shared SubWord unit.
// Define KEYEXP_STORE_EN to add an (NR+1)-entry key store with a
// combinational read port for reverse-order access by the inverse cipher.
module key_expand_ctrl
   import aes_pkg::*;
#(
   parameter int NR     = NR_128,
   parameter int RCNT_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   key_expand_ctrl_if.slave kx
);

   state_e            state_q, state_d;
   key_t              rk_data_q, rk_data_d;
   logic [RCNT_W-1:0] rk_idx_q, rk_idx_d;
   logic [7:0]        rcon_q, rcon_d;
   logic              done_q, done_d;

   word_t w0, w1, w2, w3;
   word_t rot_w, sub_w, t_w;
   word_t n0, n1, n2, n3;
   logic  hs, last;

   // Round-key recurrence from the key currently on the stream
   assign {w0, w1, w2, w3} = rk_data_q;
   assign rot_w = {w3[23:0], w3[31:24]};

   key_expand_ctrl_subword u_subword (
      .word_i (rot_w),
      .word_o (sub_w)
   );

   assign t_w = sub_w ^ {rcon_q, 24'h0};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   assign hs   = (state_q == RUN) && kx.rk_ready;
   assign last = (rk_idx_q == RCNT_W'(NR));

   // Next-state: load on start, advance only on handshake, finish after rkNR
   always_comb begin
      state_d   = state_q;
      rk_data_d = rk_data_q;
      rk_idx_d  = rk_idx_q;
      rcon_d    = rcon_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (kx.start) begin
               state_d   = RUN;
               rk_data_d = kx.key_in;
               rk_idx_d  = '0;
               rcon_d    = RCON_INIT;
            end
         end
         RUN: begin
            if (hs) begin
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rk_data_d = {n0, n1, n2, n3};
                  rk_idx_d  = rk_idx_q + RCNT_W'(1);
                  rcon_d    = xtime(rcon_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any partially streamed schedule
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rk_data_q <= '0;
         rk_idx_q  <= '0;
         rcon_q    <= RCON_INIT;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rk_data_q <= rk_data_d;
         rk_idx_q  <= rk_idx_d;
         rcon_q    <= rcon_d;
         done_q    <= done_d;
      end
   end

   assign kx.rk_valid = (state_q == RUN);
   assign kx.busy     = (state_q != IDLE);
   assign kx.rk_data  = rk_data_q;
   assign kx.rk_idx   = rk_idx_q;
   assign kx.done     = done_q;

`ifdef KEYEXP_STORE_EN
   key_t store_q [0:NR];
   logic rd_vld_q, rd_vld_d;

   // Capture each key as it is accepted by the consumer
   always_ff @(posedge clk) begin
      if (hs) begin
         store_q[rk_idx_q] <= rk_data_q;
      end
   end

   // Store becomes valid once a full schedule has been accepted; a new start invalidates it
   always_comb begin
      rd_vld_d = rd_vld_q;
      if ((state_q == IDLE) && kx.start) begin
         rd_vld_d = 1'b0;
      end else if (hs && last) begin
         rd_vld_d = 1'b1;
      end
   end

   // Store-valid flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_vld_d;
      end
   end

   assign kx.rd_vld  = rd_vld_q;
   assign kx.rd_data = (kx.rd_idx <= RCNT_W'(NR)) ? store_q[kx.rd_idx] : '0;
`endif

endmodule
